// File: rtl/add_serial_if.sv
// Handshake/data bundle for the bit-serial adder add_serial.
// Optional build macro: ADD_SERIAL_OVF_EN adds the signed-overflow flag ovf.
interface add_serial_if #(
   parameter int WIDTH = 8
) ();
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             c_in;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             c_out;
   logic             busy;
`ifdef ADD_SERIAL_OVF_EN
   logic             ovf;
`endif

   // producer/consumer side: supplies operands, takes results
   modport master (
      output in_valid, a, b, c_in, out_ready,
      input  in_ready, out_valid, sum, c_out, busy
`ifdef ADD_SERIAL_OVF_EN
      , input ovf
`endif
   );

   // adder side
   modport slave (
      input  in_valid, a, b, c_in, out_ready,
      output in_ready, out_valid, sum, c_out, busy
`ifdef ADD_SERIAL_OVF_EN
      , output ovf
`endif
   );
endinterface

// File: rtl/add_serial.sv
// Bit-serial WIDTH-bit adder: operands enter over a valid/ready handshake and
// are fed LSB first through the 1-bit full-adder cell `add`, one bit per clock.
// Optional build macro: ADD_SERIAL_OVF_EN adds a registered two's-complement
// overflow flag (carry into MSB xor carry out of MSB).

// 1-bit full-adder cell
module add (
   input  logic c,
   input  logic a,
   input  logic b,
   output logic c_out,
   output logic sum
);
   assign sum   = a ^ b ^ c;
   assign c_out = (a & b) | (c & (a ^ b));
endmodule

// State table
//   state | meaning
//   IDLE  | waiting for operands, in_ready high
//   RUN   | one bit pair per clock through the cell, busy high
//   DONE  | result held on sum/c_out, out_valid high until out_ready
module add_serial #(
   parameter int WIDTH = 8
) (
   input logic         clk,
   input logic         rst_n,
   add_serial_if.slave bus
);
   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q;
   state_t           state_d;

   logic [WIDTH-1:0] opa_q;
   logic [WIDTH-1:0] opb_q;
   logic             carry_q;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0] sum_sr_q;
   logic [WIDTH-1:0] sum_q;
   logic             cout_q;

   logic             in_ready_c;
   logic             busy_c;
   logic             out_valid_c;
   logic             accept;
   logic             run_step;
   logic             last_step;

   logic             cell_cout;
   logic             cell_sum;
   logic [WIDTH-1:0] sum_shift;

   add u_add (
      .c     (carry_q),
      .a     (opa_q[0]),
      .b     (opb_q[0]),
      .c_out (cell_cout),
      .sum   (cell_sum)
   );

   // sum register shifted right with the new cell bit entering at the MSB
   always_comb begin
      sum_shift            = sum_sr_q >> 1;
      sum_shift[WIDTH-1]   = cell_sum;
   end

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // next-state and handshake outputs
   always_comb begin
      state_d     = state_q;
      in_ready_c  = 1'b0;
      busy_c      = 1'b0;
      out_valid_c = 1'b0;
      accept      = 1'b0;
      run_step    = 1'b0;
      last_step   = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready_c = 1'b1;
            if (bus.in_valid) begin
               accept  = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            busy_c   = 1'b1;
            run_step = 1'b1;
            if (cnt_q == CNT_LAST) begin
               last_step = 1'b1;
               state_d   = DONE;
            end
         end
         DONE: begin
            out_valid_c = 1'b1;
            if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // operand/carry/counter datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         opa_q    <= '0;
         opb_q    <= '0;
         carry_q  <= 1'b0;
         cnt_q    <= '0;
         sum_sr_q <= '0;
      end else if (accept) begin
         opa_q    <= bus.a;
         opb_q    <= bus.b;
         carry_q  <= bus.c_in;
         cnt_q    <= '0;
      end else if (run_step) begin
         opa_q    <= opa_q >> 1;
         opb_q    <= opb_q >> 1;
         carry_q  <= cell_cout;
         cnt_q    <= cnt_q + CNT_W'(1);
         sum_sr_q <= sum_shift;
      end
   end

   // result registers, updated only on the final RUN cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_q  <= '0;
         cout_q <= 1'b0;
      end else if (last_step) begin
         sum_q  <= sum_shift;
         cout_q <= cell_cout;
      end
   end

`ifdef ADD_SERIAL_OVF_EN
   logic ovf_q;

   // carry_q holds the carry into the MSB during the final cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         ovf_q <= 1'b0;
      else if (last_step) ovf_q <= carry_q ^ cell_cout;
   end

   assign bus.ovf = ovf_q;
`endif

   assign bus.in_ready  = in_ready_c;
   assign bus.busy      = busy_c;
   assign bus.out_valid = out_valid_c;
   assign bus.sum       = sum_q;
   assign bus.c_out     = cout_q;
endmodule

// File: tb/tb_add_serial.sv
// Directed bench for add_serial (WIDTH=8) with a result scoreboard.
module tb_add_serial;
   localparam int W = 8;

   typedef struct packed {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
   } exp_t;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   exp_t sb[$];

   add_serial_if #(.WIDTH(W)) bus ();

   add_serial #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // waits for in_ready, presents operands for one accept edge, records the expected result
   task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
      logic [W:0] s;
      exp_t       e;
      int         n;
      n = 0;
      while (bus.in_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("in_ready_before_accept", bus.in_ready, 1);
      bus.in_valid = 1'b1;
      bus.a        = a;
      bus.b        = b;
      bus.c_in     = cin;
      @(posedge clk);
      s      = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
      e.sum  = s[W-1:0];
      e.cout = s[W];
      e.ovf  = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
      sb.push_back(e);
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk("busy_in_run", bus.busy, 1);
      chk("in_ready_in_run", bus.in_ready, 0);
   endtask

   // counts cycles from the accept edge to out_valid, then scores the result
   task automatic wait_result(input string tag);
      int   lat;
      exp_t e;
      lat = 0;
      while (bus.out_valid !== 1'b1 && lat < W + 10) begin
         @(negedge clk);
         lat++;
      end
      chk({tag, "_latency"}, lat, W);
      if (sb.size() == 0) begin
         chk({tag, "_scoreboard_nonempty"}, 0, 1);
      end else begin
         e = sb.pop_front();
         chk({tag, "_sum"}, bus.sum, e.sum);
         chk({tag, "_c_out"}, bus.c_out, e.cout);
`ifdef ADD_SERIAL_OVF_EN
         chk({tag, "_ovf"}, bus.ovf, e.ovf);
`endif
      end
      chk({tag, "_busy_done"}, bus.busy, 0);
      chk({tag, "_in_ready_done"}, bus.in_ready, 0);
   endtask

   task automatic release_result(input string tag);
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      chk({tag, "_out_valid_cleared"}, bus.out_valid, 0);
      chk({tag, "_in_ready_back"}, bus.in_ready, 1);
   endtask

   initial begin
      logic [W-1:0] held_sum;
      logic         held_cout;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rc;
      checks        = 0;
      errors        = 0;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.c_in      = 1'b0;
      bus.out_ready = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", bus.in_ready, 1);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_sum", bus.sum, 0);
      chk("rst_c_out", bus.c_out, 0);
`ifdef ADD_SERIAL_OVF_EN
      chk("rst_ovf", bus.ovf, 0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      start_op(8'h0F, 8'h01, 1'b0);
      wait_result("op_0f_01");
      release_result("op_0f_01");

      start_op(8'hFF, 8'h00, 1'b1);
      wait_result("op_ripple");
      release_result("op_ripple");

      start_op(8'hAA, 8'h55, 1'b0);
      wait_result("op_aa_55");
      held_sum     = bus.sum;
      held_cout    = bus.c_out;
      bus.in_valid = 1'b1;
      bus.a        = 8'h01;
      bus.b        = 8'h00;
      bus.c_in     = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("hold_sum", bus.sum, 8'hFF);
         chk("hold_c_out", bus.c_out, 0);
         chk("hold_in_ready", bus.in_ready, 0);
         chk("hold_out_valid", bus.out_valid, 1);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      chk("release_in_ready", bus.in_ready, 1);
      chk("release_no_same_edge_accept", bus.busy, 0);
      chk("release_out_valid", bus.out_valid, 0);
      chk("sum_kept_after_done", bus.sum, held_sum);
      chk("c_out_kept_after_done", bus.c_out, held_cout);
      bus.in_valid = 1'b0;
      @(negedge clk);

      start_op(8'hFF, 8'hFF, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("abort_out_valid", bus.out_valid, 0);
      chk("abort_busy", bus.busy, 0);
      chk("abort_in_ready", bus.in_ready, 1);
      chk("abort_sum", bus.sum, 0);
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      start_op(8'h01, 8'h01, 1'b0);
      wait_result("after_abort");
      release_result("after_abort");

      for (int i = 0; i < 4; i++) begin
         ra = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(0, 255));
         rc = 1'($urandom_range(0, 1));
         start_op(ra, rb, rc);
         wait_result("random");
         release_result("random");
      end

`ifdef ADD_SERIAL_OVF_EN
      start_op(8'h7F, 8'h01, 1'b0);
      wait_result("ovf_7f_01");
      chk("ovf_7f_01_flag", bus.ovf, 1);
      release_result("ovf_7f_01");

      start_op(8'h80, 8'h80, 1'b0);
      wait_result("ovf_80_80");
      chk("ovf_80_80_flag", bus.ovf, 1);
      release_result("ovf_80_80");

      start_op(8'h05, 8'h03, 1'b0);
      wait_result("ovf_05_03");
      chk("ovf_05_03_flag", bus.ovf, 0);
      release_result("ovf_05_03");
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
